accel_sample_sequencer: RTL and testbench

Sequencer between the accelerometer SPI controller and the 7-segment display path. It collects a block of 2^AVG_LOG2 X/Y samples on `data_update` rising edges and averages them with an arithmetic shift. It converts each average to sign plus 3-digit saturated BCD with an iterative double-dabble, then publishes both axes together with a one-cycle `frame_valid`. It replaces per-axis free-running averaging and combinational `%`/`/` digit extraction with one scheduled, multi-cycle datapath.

---
 rtl/accel_sample_sequencer_if.sv | 33 +++
 rtl/accel_sample_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_accel_sample_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_sample_sequencer_if.sv
// Sample/result bundle between the SPI controller, the sequencer and the display path.
//
// Handshake: data_update is a level strobe and a sample transfers on the clock where its
// rising edge is seen while the sequencer is idle and freeze is low. There is no back-pressure:
// edges arriving while busy are dropped and flagged on overrun. frame_valid is a one-cycle
// pulse; bcd/sign/sat stay stable until the next frame.
interface accel_sample_sequencer_if #(
  parameter int DATA_W = 16
);
  logic                     data_update;
  logic signed [DATA_W-1:0] data_x;
  logic signed [DATA_W-1:0] data_y;
  logic                     freeze;
  logic [11:0]              bcd_x;
  logic [11:0]              bcd_y;
  logic                     sign_x;
  logic                     sign_y;
  logic                     sat_x;
  logic                     sat_y;
  logic                     frame_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output data_update, data_x, data_y, freeze,
    input  bcd_x, bcd_y, sign_x, sign_y, sat_x, sat_y, frame_valid, busy, overrun
  );

  modport slave (
    input  data_update, data_x, data_y, freeze,
    output bcd_x, bcd_y, sign_x, sign_y, sat_x, sat_y, frame_valid, busy, overrun
  );
endinterface

// File: rtl/accel_sample_sequencer.sv
// Block-averages X/Y accelerometer samples, converts each average to sign + saturated 3-digit
// BCD with a 10-cycle double-dabble, and publishes both axes together.
module accel_sample_sequencer #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  accel_sample_sequencer_if.slave bus,
  output logic [1:0]              state_o
);

  localparam int AW = DATA_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] BLOCK_N = CW'(1) << AVG_LOG2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVIDE  = 2'd1,
    S_CONV    = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 upd_q;
  logic signed [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           iter_q, iter_d;
  logic [9:0]           bin_x_q, bin_x_d, bin_y_q, bin_y_d;
  logic [11:0]          dd_x_q, dd_x_d, dd_y_q, dd_y_d;
  logic                 neg_x_q, neg_x_d, neg_y_q, neg_y_d;
  logic                 satf_x_q, satf_x_d, satf_y_q, satf_y_d;
  logic                 pub_q, pub_d;
  logic [11:0]          bcd_x_q, bcd_x_d, bcd_y_q, bcd_y_d;
  logic                 sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic                 sat_x_q, sat_x_d, sat_y_q, sat_y_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 upd_edge;
  logic [DATA_W:0]      mag_x, mag_y;

  // Floored average, then magnitude at DATA_W+1 bits so the most negative sample is exact.
  function automatic logic [DATA_W:0] abs_avg(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0]   sh;
    logic signed [DATA_W:0] avg;
    sh  = acc >>> AVG_LOG2;
    avg = (DATA_W+1)'(sh);
    return avg[DATA_W] ? -avg : avg;
  endfunction

  // One double-dabble iteration: add 3 to digits >= 5, then shift {bcd, bin} left.
  function automatic logic [21:0] dd_step(input logic [11:0] bcd, input logic [9:0] bin);
    logic [11:0] adj;
    logic [21:0] cat;
    for (int k = 0; k < 3; k++) begin
      adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end
    cat = {adj, bin};
    return cat << 1;
  endfunction

  assign upd_edge = bus.data_update & ~upd_q;
  assign mag_x    = abs_avg(acc_x_q);
  assign mag_y    = abs_avg(acc_y_q);

  always_comb begin
    state_d       = state_q;
    acc_x_d       = acc_x_q;
    acc_y_d       = acc_y_q;
    cnt_d         = cnt_q;
    iter_d        = iter_q;
    bin_x_d       = bin_x_q;
    bin_y_d       = bin_y_q;
    dd_x_d        = dd_x_q;
    dd_y_d        = dd_y_q;
    neg_x_d       = neg_x_q;
    neg_y_d       = neg_y_q;
    satf_x_d      = satf_x_q;
    satf_y_d      = satf_y_q;
    pub_d         = 1'b0;
    bcd_x_d       = bcd_x_q;
    bcd_y_d       = bcd_y_q;
    sign_x_d      = sign_x_q;
    sign_y_d      = sign_y_q;
    sat_x_d       = sat_x_q;
    sat_y_d       = sat_y_q;
    frame_valid_d = 1'b0;
    overrun_d     = overrun_q | (upd_edge & (state_q != S_IDLE));

    // Results land on the output registers one cycle after PUBLISH.
    if (pub_q) begin
      bcd_x_d       = dd_x_q;
      bcd_y_d       = dd_y_q;
      sign_x_d      = neg_x_q;
      sign_y_d      = neg_y_q;
      sat_x_d       = satf_x_q;
      sat_y_d       = satf_y_q;
      frame_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (upd_edge && !bus.freeze) begin
          acc_x_d = acc_x_q + AW'(bus.data_x);
          acc_y_d = acc_y_q + AW'(bus.data_y);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == BLOCK_N) state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        neg_x_d  = acc_x_q[AW-1];
        neg_y_d  = acc_y_q[AW-1];
        satf_x_d = (mag_x > (DATA_W+1)'(999));
        satf_y_d = (mag_y > (DATA_W+1)'(999));
        bin_x_d  = satf_x_d ? 10'd999 : mag_x[9:0];
        bin_y_d  = satf_y_d ? 10'd999 : mag_y[9:0];
        acc_x_d  = '0;
        acc_y_d  = '0;
        cnt_d    = '0;
        dd_x_d   = '0;
        dd_y_d   = '0;
        iter_d   = '0;
        state_d  = S_CONV;
      end
      S_CONV: begin
        {dd_x_d, bin_x_d} = dd_step(dd_x_q, bin_x_q);
        {dd_y_d, bin_y_d} = dd_step(dd_y_q, bin_y_q);
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          iter_d  = '0;
          state_d = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        pub_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      upd_q         <= 1'b1;
      acc_x_q       <= '0;
      acc_y_q       <= '0;
      cnt_q         <= '0;
      iter_q        <= '0;
      bin_x_q       <= '0;
      bin_y_q       <= '0;
      dd_x_q        <= '0;
      dd_y_q        <= '0;
      neg_x_q       <= 1'b0;
      neg_y_q       <= 1'b0;
      satf_x_q      <= 1'b0;
      satf_y_q      <= 1'b0;
      pub_q         <= 1'b0;
      bcd_x_q       <= '0;
      bcd_y_q       <= '0;
      sign_x_q      <= 1'b0;
      sign_y_q      <= 1'b0;
      sat_x_q       <= 1'b0;
      sat_y_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      upd_q         <= bus.data_update;
      acc_x_q       <= acc_x_d;
      acc_y_q       <= acc_y_d;
      cnt_q         <= cnt_d;
      iter_q        <= iter_d;
      bin_x_q       <= bin_x_d;
      bin_y_q       <= bin_y_d;
      dd_x_q        <= dd_x_d;
      dd_y_q        <= dd_y_d;
      neg_x_q       <= neg_x_d;
      neg_y_q       <= neg_y_d;
      satf_x_q      <= satf_x_d;
      satf_y_q      <= satf_y_d;
      pub_q         <= pub_d;
      bcd_x_q       <= bcd_x_d;
      bcd_y_q       <= bcd_y_d;
      sign_x_q      <= sign_x_d;
      sign_y_q      <= sign_y_d;
      sat_x_q       <= sat_x_d;
      sat_y_q       <= sat_y_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.bcd_x       = bcd_x_q;
  assign bus.bcd_y       = bcd_y_q;
  assign bus.sign_x      = sign_x_q;
  assign bus.sign_y      = sign_y_q;
  assign bus.sat_x       = sat_x_q;
  assign bus.sat_y       = sat_y_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.overrun     = overrun_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Scoreboard bench for accel_sample_sequencer: a behavioural model predicts each frame and its
// publication cycle; the monitor pops and compares whenever frame_valid pulses.
module tb_accel_sample_sequencer;
  localparam int DATA_W   = 16;
  localparam int AVG_LOG2 = 3;
  localparam int N        = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_o;

  accel_sample_sequencer_if #(.DATA_W(DATA_W)) bus ();

  accel_sample_sequencer #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [27:0] exp_q[$];   // {sat_x, sign_x, bcd_x, sat_y, sign_y, bcd_y}
  int          exp_t_q[$]; // expected publication cycle
  int          sum_x = 0, sum_y = 0, m_cnt = 0, free_at = 0;
  logic        exp_overrun = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] model_axis(input int sum);
    int avg, mag;
    logic neg, sat;
    avg = sum >>> AVG_LOG2;
    neg = (avg < 0);
    mag = neg ? -avg : avg;
    sat = (mag > 999);
    if (sat) mag = 999;
    return {sat, neg, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_edge(input int x, input int y);
    int e;
    @(posedge clk);
    #1;
    bus.data_x      = DATA_W'(x);
    bus.data_y      = DATA_W'(y);
    bus.data_update = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    if (e < free_at) begin
      exp_overrun = 1'b1;
    end else if (!bus.freeze) begin
      sum_x += x;
      sum_y += y;
      m_cnt++;
      if (m_cnt == N) begin
        exp_q.push_back({model_axis(sum_x), model_axis(sum_y)});
        exp_t_q.push_back(e + 13);
        free_at = e + 13;
        sum_x   = 0;
        sum_y   = 0;
        m_cnt   = 0;
        check_val("busy_start", 32'(bus.busy), 32'(1));
        check_val("state_divide", 32'(state_o), 32'(1));
      end
    end
    bus.data_update = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_bcd_x"}, 32'(bus.bcd_x), 32'(0));
    check_val({tag, "_bcd_y"}, 32'(bus.bcd_y), 32'(0));
    check_val({tag, "_signs"}, 32'({bus.sign_x, bus.sign_y}), 32'(0));
    check_val({tag, "_sats"}, 32'({bus.sat_x, bus.sat_y}), 32'(0));
    check_val({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'(0));
    check_val({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check_val({tag, "_overrun"}, 32'(bus.overrun), 32'(0));
    check_val({tag, "_state"}, 32'(state_o), 32'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [27:0] ex;
    int          t;
    if (!rst && bus.frame_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_frame", 32'(bus.frame_valid), 32'(0));
      end else begin
        ex = exp_q.pop_front();
        t  = exp_t_q.pop_front();
        check_val("frame_cycle", 32'(cyc), 32'(t));
        check_val("bcd_x", 32'(bus.bcd_x), 32'(ex[25:14]));
        check_val("sign_x", 32'(bus.sign_x), 32'(ex[26]));
        check_val("sat_x", 32'(bus.sat_x), 32'(ex[27]));
        check_val("bcd_y", 32'(bus.bcd_y), 32'(ex[11:0]));
        check_val("sign_y", 32'(bus.sign_y), 32'(ex[12]));
        check_val("sat_y", 32'(bus.sat_y), 32'(ex[13]));
        check_val("busy_at_frame", 32'(bus.busy), 32'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ys[8];
    bus.data_update = 1'b0;
    bus.freeze      = 1'b0;
    bus.data_x      = '0;
    bus.data_y      = '0;
    idle(2);
    rst = 1'b0;
    idle(1);
    check_outputs_zero("reset");

    // Positive average
    for (int i = 0; i < N; i++) drive_edge(100, 250);
    idle(16);

    // Negative values and floor rounding
    ys = '{-1, -1, -1, -1, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) drive_edge(-5, ys[i]);
    idle(16);

    // Saturation and the most negative sample
    for (int i = 0; i < N; i++) drive_edge(1200, -32768);
    idle(16);

    // Overrun: a rising edge 4 cycles after the final edge of a block
    for (int i = 0; i < N; i++)
      drive_edge(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
    idle(2);
    drive_edge(777, 777);
    check_val("overrun_set", 32'(bus.overrun), 32'(exp_overrun));
    idle(14);
    for (int i = 0; i < N; i++)
      drive_edge(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
    idle(16);
    check_val("overrun_sticky", 32'(bus.overrun), 32'(exp_overrun));

    // Freeze holds a partial block
    for (int i = 0; i < 3; i++) drive_edge(500, -600);
    bus.freeze = 1'b1;
    for (int i = 0; i < 5; i++) drive_edge(999, 999);
    idle(20);
    check_val("freeze_state", 32'(state_o), 32'(0));
    check_val("freeze_busy", 32'(bus.busy), 32'(0));
    bus.freeze = 1'b0;
    for (int i = 0; i < 5; i++) drive_edge(-100, 20);
    idle(16);

    // Reset during CONV with data_update held high through reset release
    for (int i = 0; i < N; i++) drive_edge(321, -77);
    idle(4);
    check_val("in_conv", 32'(state_o), 32'(2));
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus.data_update = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    sum_x       = 0;
    sum_y       = 0;
    m_cnt       = 0;
    free_at     = 0;
    exp_overrun = 1'b0;
    check_outputs_zero("post_reset");
    idle(3);
    check_val("held_level_state", 32'(state_o), 32'(0));
    bus.data_update = 1'b0;
    for (int i = 0; i < N; i++) drive_edge(42, -42);
    idle(2);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_val("pending_frames", 32'(exp_q.size()), 32'(0));
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
